lstm_input_feeder: RTL and testbench

Double-buffered packer that sits directly upstream of the LSTM cell. It accepts 64-bit trace words from the tokenizer and assembles them into 512-bit LSTM input records: 1 word for SYSTEM, 8 words for BRANCH. It issues each record to the cell with a one-cycle next-valid pulse and holds `oData`/`oMode` stable until the cell reports completion. While one record is being consumed, the next one fills the other buffer.

---
 rtl/lstm_input_feeder.sv | 184 ++++++++++++++++++
 tb/tb_lstm_input_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_input_feeder.sv
// Double-buffered 64b->512b record packer feeding the LSTM cell; optional issue counters under LSTM_FEED_CNT_EN.
// Latency: final word accepted at edge k -> oNext_valid high after edge k+1 for one cycle; pulses >= 3 cycles apart.
// Backpressure: oWord_ready drops while the fill buffer is full (both buffers held) or during iFlush.
module lstm_input_feeder #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [63:0]  iWord,
    input  logic         iWord_valid,
    input  logic         iWord_mode,
    output logic         oWord_ready,
    input  logic         iFlush,
    input  logic         iLstm_done,
    output logic         oNext_valid,
    output logic         oMode,
    output logic [511:0] oData,
    output logic         oTimeout_err
`ifdef LSTM_FEED_CNT_EN
    ,
    output logic [15:0]  oSys_cnt,
    output logic [15:0]  oBr_cnt
`endif
);

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {I_IDLE, I_WAIT_BUSY, I_WAIT_DONE} istate_t;

    istate_t            state_q, state_d;
    logic [1:0][511:0]  data_q, data_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         full_q, full_d;
    logic               fptr_q, fptr_d;
    logic               iptr_q, iptr_d;
    logic [2:0]         wcnt_q, wcnt_d;
    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               next_valid_q, next_valid_d;
    logic               timeout_err_q, timeout_err_d;
    logic               word_rdy, accept, cur_mode, buf_free;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        mode_d        = mode_q;
        full_d        = full_q;
        fptr_d        = fptr_q;
        iptr_d        = iptr_q;
        wcnt_d        = wcnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        next_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        buf_free      = 1'b0;

        word_rdy = !full_q[fptr_q] && !iFlush;
        accept   = iWord_valid && word_rdy;
        cur_mode = (wcnt_q == 3'd0) ? iWord_mode : mode_q[fptr_q];

        if (accept) begin
            mode_d[fptr_q] = cur_mode;
            if (!cur_mode) begin
                data_d[fptr_q] = {448'b0, iWord};
                full_d[fptr_q] = 1'b1;
                fptr_d         = ~fptr_q;
                wcnt_d         = 3'd0;
            end else begin
                // word n lands at [511-64n -: 64]; {~n, 6'h3f} is that top bit index
                data_d[fptr_q][{~wcnt_q, 6'h3f} -: 64] = iWord;
                if (wcnt_q == 3'd7) begin
                    full_d[fptr_q] = 1'b1;
                    fptr_d         = ~fptr_q;
                    wcnt_d         = 3'd0;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
        end

        case (state_q)
            I_IDLE: begin
                // a flush discards the pending record, so it must not issue in the same cycle
                if (full_q[iptr_q] && iLstm_done && !iFlush) begin
                    next_valid_d = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = I_WAIT_BUSY;
                end
            end
            I_WAIT_BUSY: begin
                if (!iLstm_done) begin
                    state_d = I_WAIT_DONE;
                end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    buf_free      = 1'b1;
                    state_d       = I_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            I_WAIT_DONE: begin
                if (iLstm_done) begin
                    buf_free = 1'b1;
                    state_d  = I_IDLE;
                end
            end
            default: state_d = I_IDLE;
        endcase

        if (buf_free) begin
            full_d[iptr_q] = 1'b0;
            iptr_d         = ~iptr_q;
        end

        if (iFlush) begin
            wcnt_d = 3'd0;
            if (state_q == I_IDLE) begin
                full_d = 2'b00;
                fptr_d = iptr_q;
            end else begin
                full_d[~iptr_q] = 1'b0;
                fptr_d          = ~iptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= I_IDLE;
            data_q        <= '0;
            mode_q        <= '0;
            full_q        <= '0;
            fptr_q        <= 1'b0;
            iptr_q        <= 1'b0;
            wcnt_q        <= '0;
            tmo_cnt_q     <= '0;
            next_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            mode_q        <= mode_d;
            full_q        <= full_d;
            fptr_q        <= fptr_d;
            iptr_q        <= iptr_d;
            wcnt_q        <= wcnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            next_valid_q  <= next_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign oWord_ready  = word_rdy;
    assign oNext_valid  = next_valid_q;
    assign oMode        = mode_q[iptr_q];
    assign oData        = data_q[iptr_q];
    assign oTimeout_err = timeout_err_q;

`ifdef LSTM_FEED_CNT_EN
    logic [15:0] sys_cnt_q, sys_cnt_d;
    logic [15:0] br_cnt_q, br_cnt_d;

    always_comb begin
        sys_cnt_d = sys_cnt_q;
        br_cnt_d  = br_cnt_q;
        if (next_valid_d) begin
            if (!mode_q[iptr_q] && sys_cnt_q != 16'hFFFF) sys_cnt_d = sys_cnt_q + 16'd1;
            if (mode_q[iptr_q] && br_cnt_q != 16'hFFFF)   br_cnt_d  = br_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sys_cnt_q <= '0;
            br_cnt_q  <= '0;
        end else begin
            sys_cnt_q <= sys_cnt_d;
            br_cnt_q  <= br_cnt_d;
        end
    end

    assign oSys_cnt = sys_cnt_q;
    assign oBr_cnt  = br_cnt_q;
`endif

endmodule

// File: tb/tb_lstm_input_feeder.sv
// Directed bench for lstm_input_feeder: vector table for SYSTEM/BRANCH records, hand sequences for corner cases.
module tb_lstm_input_feeder;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [63:0]  iWord = '0;
    logic         iWord_valid = 1'b0;
    logic         iWord_mode = 1'b0;
    logic         oWord_ready;
    logic         iFlush = 1'b0;
    logic         iLstm_done = 1'b1;
    logic         oNext_valid;
    logic         oMode;
    logic [511:0] oData;
    logic         oTimeout_err;
`ifdef LSTM_FEED_CNT_EN
    logic [15:0]  oSys_cnt;
    logic [15:0]  oBr_cnt;
`endif

    lstm_input_feeder #(.BUSY_TIMEOUT(16)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .iWord        (iWord),
        .iWord_valid  (iWord_valid),
        .iWord_mode   (iWord_mode),
        .oWord_ready  (oWord_ready),
        .iFlush       (iFlush),
        .iLstm_done   (iLstm_done),
        .oNext_valid  (oNext_valid),
        .oMode        (oMode),
        .oData        (oData),
        .oTimeout_err (oTimeout_err)
`ifdef LSTM_FEED_CNT_EN
        ,
        .oSys_cnt     (oSys_cnt),
        .oBr_cnt      (oBr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         v;
        logic         m;
        logic [63:0]  w;
        logic         done;
        logic         exp_rdy;
        logic         exp_nv;
        logic         exp_mode;
        logic [511:0] exp_d;
    } vec_t;

    vec_t tv[15];

    localparam logic [63:0] W_SYS = 64'h0123_4567_89AB_CDEF;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic m, input logic [63:0] w, input logic d,
                                input logic r, input logic nv, input logic md, input logic [511:0] ed);
        vec_t t;
        t.v = v; t.m = m; t.w = w; t.done = d;
        t.exp_rdy = r; t.exp_nv = nv; t.exp_mode = md; t.exp_d = ed;
        return t;
    endfunction

    function automatic logic [511:0] brd(input int n);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[511 - 64*i -: 64] = 64'(i + 1);
        return d;
    endfunction

    function automatic logic [511:0] sysd(input logic [63:0] w);
        return {448'h0, w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [63:0] w);
        iWord_valid = v;
        iWord_mode  = m;
        iWord       = w;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 64'h0);
        iFlush     = 1'b0;
        iLstm_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_rdy",  {511'h0, oWord_ready},  512'h1);
        chk("reset_nv",   {511'h0, oNext_valid},  512'h0);
        chk("reset_mode", {511'h0, oMode},        512'h0);
        chk("reset_data", oData,                  512'h0);
        chk("reset_terr", {511'h0, oTimeout_err}, 512'h0);
`ifdef LSTM_FEED_CNT_EN
        chk("reset_cnt", {480'h0, oSys_cnt, oBr_cnt}, 512'h0);
`endif

        // SYSTEM record, then a BRANCH record whose later words carry a stray mode=0
        tv[0]  = mk(1, 0, W_SYS, 1, 1, 0, 0, sysd(W_SYS));
        tv[1]  = mk(0, 0, 0,     1, 1, 1, 0, sysd(W_SYS));
        tv[2]  = mk(0, 0, 0,     0, 1, 0, 0, sysd(W_SYS));
        tv[3]  = mk(0, 0, 0,     1, 1, 0, 0, 512'h0);
        tv[4]  = mk(1, 1, 64'd1, 1, 1, 0, 1, brd(1));
        for (int n = 2; n <= 8; n++)
            tv[n + 3] = mk(1, 0, 64'(n), 1, 1, 0, 1, brd(n));
        tv[12] = mk(0, 0, 0,     1, 1, 1, 1, brd(8));
        tv[13] = mk(0, 0, 0,     0, 1, 0, 1, brd(8));
        tv[14] = mk(0, 0, 0,     1, 1, 0, 0, sysd(W_SYS));

        for (int i = 0; i < 15; i++) begin
            drive(tv[i].v, tv[i].m, tv[i].w);
            iLstm_done = tv[i].done;
            step();
            chk($sformatf("vec%0d_rdy", i),  {511'h0, oWord_ready}, {511'h0, tv[i].exp_rdy});
            chk($sformatf("vec%0d_nv", i),   {511'h0, oNext_valid}, {511'h0, tv[i].exp_nv});
            chk($sformatf("vec%0d_mode", i), {511'h0, oMode},       {511'h0, tv[i].exp_mode});
            chk($sformatf("vec%0d_data", i), oData,                 tv[i].exp_d);
        end

        // back-pressure: A issued and held busy, B fills, C must wait
        do_reset();
        drive(1, 0, 64'hA); step();
        drive(1, 0, 64'hB); step();
        chk("bp_issueA_nv",  {511'h0, oNext_valid}, 512'h1);
        chk("bp_both_full",  {511'h0, oWord_ready}, 512'h0);
        iLstm_done = 1'b0;
        drive(1, 0, 64'hC);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bp_hold%0d_rdy", i),  {511'h0, oWord_ready}, 512'h0);
            chk($sformatf("bp_hold%0d_data", i), oData, sysd(64'hA));
        end
        iLstm_done = 1'b1;
        step();
        chk("bp_free_rdy",  {511'h0, oWord_ready}, 512'h1);
        chk("bp_free_nv",   {511'h0, oNext_valid}, 512'h0);
        chk("bp_free_data", oData, sysd(64'hB));
        step();
        chk("bp_issueB_nv",   {511'h0, oNext_valid}, 512'h1);
        chk("bp_issueB_rdy",  {511'h0, oWord_ready}, 512'h0);
        chk("bp_issueB_data", oData, sysd(64'hB));
        drive(0, 0, 64'h0);
        iLstm_done = 1'b0; step();
        iLstm_done = 1'b1; step();
        chk("bp_freeB_data", oData, sysd(64'hC));
        step();
        chk("bp_issueC_nv",   {511'h0, oNext_valid}, 512'h1);
        chk("bp_issueC_data", oData, sysd(64'hC));
        iLstm_done = 1'b0; step();
        iLstm_done = 1'b1; step();
        chk("bp_drained_rdy", {511'h0, oWord_ready}, 512'h1);
        step();
        chk("bp_no_dup_nv", {511'h0, oNext_valid}, 512'h0);

        // timeout: done never falls
        do_reset();
        drive(1, 0, 64'h71); step();
        drive(1, 0, 64'h72); step();
        chk("to_issue_nv", {511'h0, oNext_valid}, 512'h1);
        drive(0, 0, 64'h0);
        repeat (15) step();
        chk("to_before_terr", {511'h0, oTimeout_err}, 512'h0);
        chk("to_before_data", oData, sysd(64'h71));
        step();
        chk("to_terr",      {511'h0, oTimeout_err}, 512'h1);
        chk("to_freed_data", oData, sysd(64'h72));
        chk("to_freed_nv",  {511'h0, oNext_valid}, 512'h0);
        step();
        chk("to_next_nv",   {511'h0, oNext_valid}, 512'h1);
        chk("to_sticky",    {511'h0, oTimeout_err}, 512'h1);

        // asynchronous reset in the middle of an issue pulse
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_nv",   {511'h0, oNext_valid},  512'h0);
        chk("areset_terr", {511'h0, oTimeout_err}, 512'h0);
        chk("areset_data", oData, 512'h0);
        chk("areset_rdy",  {511'h0, oWord_ready},  512'h1);
        do_reset();

        // flush while A is issued and a BRANCH record is partially filled
        drive(1, 0, 64'hAAAA); step();
        drive(1, 1, 64'd1); step();
        iLstm_done = 1'b0;
        drive(1, 1, 64'd2); step();
        drive(1, 1, 64'd3); step();
        drive(1, 1, 64'hDEAD);
        iFlush = 1'b1;
        #1;
        chk("fl_rdy_low", {511'h0, oWord_ready}, 512'h0);
        step();
        iFlush = 1'b0;
        drive(0, 0, 64'h0);
        chk("fl_keepA_data", oData, sysd(64'hAAAA));
        step();
        chk("fl_keepA_data2", oData, sysd(64'hAAAA));
        iLstm_done = 1'b1; step();
        chk("fl_after_free_nv", {511'h0, oNext_valid}, 512'h0);
        drive(1, 0, 64'h5555); step();
        drive(0, 0, 64'h0);
        chk("fl_sys_nv0", {511'h0, oNext_valid}, 512'h0);
        step();
        chk("fl_sys_nv",   {511'h0, oNext_valid}, 512'h1);
        chk("fl_sys_mode", {511'h0, oMode},       512'h0);
        chk("fl_sys_data", oData, sysd(64'h5555));

        // flush in idle discards a complete, not yet issued record
        do_reset();
        iLstm_done = 1'b0;
        drive(1, 0, 64'hF0); step();
        drive(0, 0, 64'h0);
        iFlush = 1'b1; step();
        iFlush = 1'b0;
        iLstm_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fli%0d_nv", i), {511'h0, oNext_valid}, 512'h0);
        end
        chk("fli_rdy", {511'h0, oWord_ready}, 512'h1);

`ifdef LSTM_FEED_CNT_EN
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1, 0, 64'(r + 1)); step();
            drive(0, 0, 64'h0); step();
            iLstm_done = 1'b0; step();
            iLstm_done = 1'b1; step();
        end
        for (int n = 1; n <= 8; n++) begin
            drive(1, 1, 64'(n)); step();
        end
        drive(0, 0, 64'h0); step();
        iLstm_done = 1'b0; step();
        iLstm_done = 1'b1; step();
        chk("cnt_sys", {496'h0, oSys_cnt}, 512'd2);
        chk("cnt_br",  {496'h0, oBr_cnt},  512'd1);
        drive(1, 0, 64'h9); step();
        #2;
        resetn = 1'b0;
        #1;
        chk("cnt_reset", {480'h0, oSys_cnt, oBr_cnt}, 512'h0);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
